// File: rtl/fp19_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp19_mul_pipe
//  Description : Three-stage pipelined multiplier for the 19-bit float format
//                {sign, exp[7:0] bias 127, frac[9:0]}. It uses a valid/ready
//                handshake with a full-pipeline stall. A sideband tag travels
//                with every operation.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   operand pair valid
//    in_ready   out  operand pair accepted this cycle (global enable)
//    in_a/in_b  in   19-bit operands
//    in_tag     in   sideband tag, returned with the product
//    out_valid  out  product valid
//    out_ready  in   downstream accepts product
//    out_data   out  19-bit product
//    out_exc    out  exception flag (special operand or exponent overflow)
//    out_tag    out  tag of the product on out_data
// ============================================================================
module fp19_mul_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [18:0]      in_a,
    input  logic [18:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [18:0]      out_data,
    output logic             out_exc,
    output logic [TAG_W-1:0] out_tag
);

    // Pipeline enable. All stages advance or freeze together.
    logic w_en;

    // ---------------- Stage 1: unpack ----------------
    logic [7:0]       w_exp_a, w_exp_b;
    logic [10:0]      s1_man_a_d, s1_man_b_d;
    logic [9:0]       s1_esum_d;
    logic             s1_sign_d, s1_spec_d, s1_zero_d;

    logic             s1_valid_q, s1_sign_q, s1_spec_q, s1_zero_q;
    logic [10:0]      s1_man_a_q, s1_man_b_q;
    logic [9:0]       s1_esum_q;
    logic [TAG_W-1:0] s1_tag_q;

    // ---------------- Stage 2: multiply ----------------
    // Only product bits [21:10] are kept: truncation discards the rest.
    logic [11:0]      s2_phi_d;
    logic [9:0]       s2_exp_d;

    logic             s2_valid_q, s2_sign_q, s2_spec_q, s2_zero_q;
    logic [11:0]      s2_phi_q;
    logic [9:0]       s2_exp_q;
    logic [TAG_W-1:0] s2_tag_q;

    // ---------------- Stage 3: normalize / pack ----------------
    logic signed [9:0] w_exp_n;
    logic [9:0]        w_frac;
    logic              w_ovf, w_unf;
    logic [18:0]       out_data_d;
    logic              out_exc_d;

    logic              out_valid_q, out_exc_q;
    logic [18:0]       out_data_q;
    logic [TAG_W-1:0]  out_tag_q;

    assign w_en     = ~out_valid_q | out_ready;
    assign in_ready = w_en;

    // Stage 1 combinational decode
    assign w_exp_a    = in_a[17:10];
    assign w_exp_b    = in_b[17:10];
    assign s1_sign_d  = in_a[18] ^ in_b[18];
    assign s1_man_a_d = {|w_exp_a, in_a[9:0]};
    assign s1_man_b_d = {|w_exp_b, in_b[9:0]};
    assign s1_esum_d  = {2'b00, w_exp_a} + {2'b00, w_exp_b};
    assign s1_spec_d  = (&w_exp_a) | (&w_exp_b);
    assign s1_zero_d  = ~(|w_exp_a) | ~(|w_exp_b);

    // Stage 2 combinational multiply and bias removal
    assign s2_phi_d = 12'((22'(s1_man_a_q) * 22'(s1_man_b_q)) >> 10);
    assign s2_exp_d = s1_esum_q - 10'd127;

    // Stage 3 combinational normalize and pack
    always_comb begin
        w_exp_n    = $signed(s2_exp_q);
        w_frac     = s2_phi_q[9:0];
        if (s2_phi_q[11]) begin
            // Product in [2,4): shift right one place and bump the exponent.
            w_exp_n = $signed(s2_exp_q + 10'd1);
            w_frac  = s2_phi_q[10:1];
        end
        w_ovf      = (w_exp_n >= 10'sd255);
        w_unf      = (w_exp_n <= 10'sd0);
        out_data_d = {s2_sign_q, w_exp_n[7:0], w_frac};
        out_exc_d  = 1'b0;
        if (s2_spec_q || w_ovf) begin
            out_data_d = 19'd0;
            out_exc_d  = 1'b1;
        end else if (s2_zero_q || w_unf) begin
            out_data_d = 19'd0;
        end
    end

    // Stage registers. Valid bits advance on every enabled cycle so bubbles
    // move through; payload only loads behind a valid slot so the output
    // registers keep their last product while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_spec_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_man_a_q  <= 11'd0;
            s1_man_b_q  <= 11'd0;
            s1_esum_q   <= 10'd0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_spec_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_phi_q    <= 12'd0;
            s2_exp_q    <= 10'd0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 19'd0;
            out_exc_q   <= 1'b0;
            out_tag_q   <= '0;
        end else if (w_en) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (in_valid) begin
                s1_sign_q  <= s1_sign_d;
                s1_spec_q  <= s1_spec_d;
                s1_zero_q  <= s1_zero_d;
                s1_man_a_q <= s1_man_a_d;
                s1_man_b_q <= s1_man_b_d;
                s1_esum_q  <= s1_esum_d;
                s1_tag_q   <= in_tag;
            end
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_spec_q <= s1_spec_q;
                s2_zero_q <= s1_zero_q;
                s2_phi_q  <= s2_phi_d;
                s2_exp_q  <= s2_exp_d;
                s2_tag_q  <= s1_tag_q;
            end
            if (s2_valid_q) begin
                out_data_q <= out_data_d;
                out_exc_q  <= out_exc_d;
                out_tag_q  <= s2_tag_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_exc   = out_exc_q;
    assign out_tag   = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_fp19_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp19_mul_pipe
//  Description : Self-checking bench for fp19_mul_pipe. Expected products are
//                queued when an operand pair is accepted and compared when
//                the DUT hands a product downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp19_mul_pipe;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [18:0]      in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [18:0]      out_data;
    logic             out_exc;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    fp19_mul_pipe #(.TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_exc  (out_exc),
        .out_tag  (out_tag)
    );

    typedef struct packed {
        logic [18:0]      data;
        logic             exc;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   n_snap;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Independent reference: returns {exc, data}.
    function automatic logic [19:0] ref_mul(input logic [18:0] a, input logic [18:0] b);
        int unsigned ea = a[17:10];
        int unsigned eb = b[17:10];
        int unsigned ma, mb, mp, fr;
        int e;
        if (ea == 255 || eb == 255) return {1'b1, 19'd0};
        ma = (ea == 0) ? a[9:0] : 1024 + a[9:0];
        mb = (eb == 0) ? b[9:0] : 1024 + b[9:0];
        mp = ma * mb;
        e  = int'(ea) + int'(eb) - 127;
        if (mp >= 32'h200000) begin
            e  = e + 1;
            fr = (mp / 2048) % 1024;
        end else begin
            fr = (mp / 1024) % 1024;
        end
        if (e >= 255) return {1'b1, 19'd0};
        if (ea == 0 || eb == 0 || e <= 0) return 20'd0;
        return {1'b0, a[18] ^ b[18], 8'(e), 10'(fr)};
    endfunction

    // Drive one operand pair; expected result queued on acceptance.
    task automatic send(input logic [18:0] a, input logic [18:0] b, input logic [TAG_W-1:0] t,
                        input logic [18:0] ed, input logic ee);
        bit got = 1'b0;
        exp_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        if (got) begin
            e.data = ed;
            e.exc  = ee;
            e.tag  = t;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [18:0] a, input logic [18:0] b, input logic [TAG_W-1:0] t);
        logic [19:0] r;
        r = ref_mul(a, b);
        send(a, b, t, r[18:0], r[19]);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: a transfer happens at the next edge when valid & ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("out_data", {13'd0, out_data}, {13'd0, mon_e.data});
                chk("out_exc",  {31'd0, out_exc},  {31'd0, mon_e.exc});
                chk("out_tag",  {28'd0, out_tag},  {28'd0, mon_e.tag});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 19'd0;
        in_b      = 19'd0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_data",  {13'd0, out_data},  32'd0);
        chk("rst_out_exc",   {31'd0, out_exc},   32'd0);
        chk("rst_out_tag",   {28'd0, out_tag},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1.5 x 1.5 with latency check
        send(19'h1FE00, 19'h1FE00, 4'd3, 19'h20080, 1'b0);
        chk("lat_accept", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_e1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_e2", {31'd0, out_valid}, 32'd1);
        drain();

        // Back-to-back stream
        send(19'h1FE00, 19'h20000, 4'd5, 19'h20200, 1'b0);
        send(19'h5FC00, 19'h1FC00, 4'd6, 19'h5FC00, 1'b0);
        drain();

        // Specials and flush
        send(19'h3FC00, 19'h1FC00, 4'd7, 19'h00000, 1'b1);
        send(19'h3C000, 19'h3C000, 4'd8, 19'h00000, 1'b1);
        send(19'h04000, 19'h04000, 4'd9, 19'h00000, 1'b0);
        send(19'h00123, 19'h1FC00, 4'd10, 19'h00000, 1'b0);
        // Exponent boundaries around 255 and 0
        send(19'h2F800, 19'h2FC00, 4'd11, 19'h3F800, 1'b0);
        send(19'h2FA00, 19'h2FE00, 4'd12, 19'h00000, 1'b1);
        send(19'h0FC00, 19'h10000, 4'd13, 19'h00000, 1'b0);
        send(19'h0FE00, 19'h10200, 4'd14, 19'h00480, 1'b0);
        drain();

        // Random operands checked against the reference model
        for (int i = 0; i < 12; i++) begin
            send_m({1'($urandom), 8'($urandom_range(100, 160)), 10'($urandom)},
                   {1'($urandom), 8'($urandom_range(90, 170)), 10'($urandom)},
                   4'(i));
        end
        drain();

        // Backpressure: three ops fill the pipe, output held for 5 cycles
        out_ready = 1'b0;
        send(19'h1FE00, 19'h1FE00, 4'd1, 19'h20080, 1'b0);
        send(19'h1FE00, 19'h20000, 4'd2, 19'h20200, 1'b0);
        send(19'h5FC00, 19'h1FC00, 4'd3, 19'h5FC00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data",  {13'd0, out_data},  32'h20080);
            chk("bp_out_tag",   {28'd0, out_tag},   32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        chk("bp_after_valid", {31'd0, out_valid}, 32'd0);
        drain();

        // Reset mid-stream with two ops in flight
        out_ready = 1'b0;
        send(19'h1FE00, 19'h20000, 4'd9, 19'h20200, 1'b0);
        send(19'h1FE00, 19'h1FE00, 4'd10, 19'h20080, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data",     {13'd0, out_data},  32'd0);
        chk("mid_rst_exc",      {31'd0, out_exc},   32'd0);
        chk("mid_rst_tag",      {28'd0, out_tag},   32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready},  32'd1);
        sb.delete();
        n_snap = n_out;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_output", 32'(n_out - n_snap), 32'd0);
        chk("post_rst_valid",  {31'd0, out_valid},  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
